// File: rtl/multi_cycle_ctrl.sv
// Multicycle control FSM for the MIPS-subset datapath.
// It steps each instruction through IF/ID/EX/MEM/WB and drives the datapath
// control lines. It also waits on the memory ready handshakes with a bounded
// timeout, and reports opcodes and functs it does not recognise.
module multi_cycle_ctrl #(
   parameter int ALUOP_W     = 3,
   parameter int MEM_TIMEOUT = 15,
   parameter int TO_W        = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [5:0]         op,
   input  logic [5:0]         funct,
   input  logic               zero,
   input  logic               imem_ready,
   input  logic               dmem_ready,
   output logic               imem_req,
   output logic               ir_write,
   output logic               pc_write,
   output logic [1:0]         pc_src,
   output logic               reg_write,
   output logic               regdst,
   output logic               extop,
   output logic               alusrc,
   output logic [ALUOP_W-1:0] aluop,
   output logic               memread,
   output logic               memwrite,
   output logic               illegal,
   output logic               bus_err,
   output logic               instr_done,
   output logic [2:0]         state
);

   // ALU operation encodings shared with the datapath ALU
   localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
   localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
   localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(2);
   localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3);
   localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(4);
   localparam logic [ALUOP_W-1:0] ALU_LUI = ALUOP_W'(5);

   localparam logic [5:0] OP_R     = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] F_ADD  = 6'b100000;
   localparam logic [5:0] F_ADDU = 6'b100001;
   localparam logic [5:0] F_SUBU = 6'b100011;
   localparam logic [5:0] F_AND  = 6'b100100;
   localparam logic [5:0] F_OR   = 6'b100101;
   localparam logic [5:0] F_SLT  = 6'b101010;

   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);
   localparam bit              TO_EN    = (MEM_TIMEOUT != 0);

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EX  = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4
   } state_t;

   state_t             state_reg, state_next;
   logic               run_reg;
   logic [TO_W-1:0]    to_cnt_reg;
   logic               regdst_reg, extop_reg, alusrc_reg;
   logic [ALUOP_W-1:0] aluop_reg;
   logic               is_lw_reg, is_sw_reg, is_beq_reg;

   logic               dec_valid, dec_j, dec_lw, dec_sw, dec_beq;
   logic               dec_regdst, dec_extop, dec_alusrc;
   logic [ALUOP_W-1:0] dec_aluop;
   logic               awaiting, ready_sel, timeout_hit, ctl_load;

   // Instruction decode of the current IR fields; only consumed in ID
   always_comb begin
      dec_valid  = 1'b0;
      dec_j      = 1'b0;
      dec_lw     = 1'b0;
      dec_sw     = 1'b0;
      dec_beq    = 1'b0;
      dec_regdst = 1'b0;
      dec_extop  = 1'b0;
      dec_alusrc = 1'b0;
      dec_aluop  = ALU_ADD;
      case (op)
         OP_R: begin
            dec_regdst = 1'b1;
            dec_valid  = 1'b1;
            case (funct)
               F_ADD, F_ADDU: dec_aluop = ALU_ADD;
               F_SUBU:        dec_aluop = ALU_SUB;
               F_AND:         dec_aluop = ALU_AND;
               F_OR:          dec_aluop = ALU_OR;
               F_SLT:         dec_aluop = ALU_SLT;
               default:       dec_valid = 1'b0;
            endcase
         end
         OP_ADDI, OP_ADDIU: begin
            dec_valid  = 1'b1;
            dec_extop  = 1'b1;
            dec_alusrc = 1'b1;
         end
         OP_ANDI: begin
            dec_valid  = 1'b1;
            dec_alusrc = 1'b1;
            dec_aluop  = ALU_AND;
         end
         OP_ORI: begin
            dec_valid  = 1'b1;
            dec_alusrc = 1'b1;
            dec_aluop  = ALU_OR;
         end
         OP_LUI: begin
            dec_valid  = 1'b1;
            dec_alusrc = 1'b1;
            dec_aluop  = ALU_LUI;
         end
         OP_LW, OP_SW: begin
            dec_valid  = 1'b1;
            dec_extop  = 1'b1;
            dec_alusrc = 1'b1;
            dec_lw     = (op == OP_LW);
            dec_sw     = (op == OP_SW);
         end
         OP_BEQ: begin
            dec_valid = 1'b1;
            dec_extop = 1'b1;
            dec_aluop = ALU_SUB;
            dec_beq   = 1'b1;
         end
         OP_J: begin
            dec_valid = 1'b1;
            dec_j     = 1'b1;
         end
         default: ;
      endcase
   end

   // A timeout can only fire while IF or MEM is waiting on its own ready
   always_comb begin
      awaiting    = ((state_reg == S_IF) && run_reg) || (state_reg == S_MEM);
      ready_sel   = (state_reg == S_IF) ? imem_ready : dmem_ready;
      timeout_hit = TO_EN && awaiting && !ready_sel && (to_cnt_reg == TO_LIMIT);
      ctl_load    = (state_reg == S_ID) && dec_valid && !dec_j;
   end

   // Next-state and control outputs. Strobes are Moore; only the load
   // enables and completion pulses look at ready in the same cycle.
   always_comb begin
      state_next = state_reg;
      imem_req   = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'd0;
      reg_write  = 1'b0;
      memread    = 1'b0;
      memwrite   = 1'b0;
      illegal    = 1'b0;
      bus_err    = 1'b0;
      instr_done = 1'b0;
      case (state_reg)
         S_IF: begin
            if (run_reg) begin
               imem_req = 1'b1;
               if (imem_ready) begin
                  ir_write   = 1'b1;
                  pc_write   = 1'b1;
                  state_next = S_ID;
               end else if (timeout_hit) begin
                  bus_err = 1'b1;
               end
            end
         end
         S_ID: begin
            if (!dec_valid) begin
               illegal    = 1'b1;
               instr_done = 1'b1;
               state_next = S_IF;
            end else if (dec_j) begin
               pc_write   = 1'b1;
               pc_src     = 2'd2;
               instr_done = 1'b1;
               state_next = S_IF;
            end else begin
               state_next = S_EX;
            end
         end
         S_EX: begin
            if (is_beq_reg) begin
               pc_src     = 2'd1;
               pc_write   = zero;
               instr_done = 1'b1;
               state_next = S_IF;
            end else if (is_lw_reg || is_sw_reg) begin
               state_next = S_MEM;
            end else begin
               state_next = S_WB;
            end
         end
         S_MEM: begin
            memread  = is_lw_reg;
            memwrite = is_sw_reg;
            if (dmem_ready) begin
               if (is_lw_reg) begin
                  state_next = S_WB;
               end else begin
                  instr_done = 1'b1;
                  state_next = S_IF;
               end
            end else if (timeout_hit) begin
               bus_err    = 1'b1;
               instr_done = 1'b1;
               state_next = S_IF;
            end
         end
         S_WB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_next = S_IF;
         end
         default: state_next = S_IF;
      endcase
   end

   // State register; run_reg holds off the first fetch until one edge after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_IF;
         run_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         run_reg   <= 1'b1;
      end
   end

   // Wait counter: restarts on every state entry and after an IF retry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt_reg <= '0;
      end else if ((state_next != state_reg) || timeout_hit) begin
         to_cnt_reg <= '0;
      end else if (awaiting && !ready_sel && (to_cnt_reg != '1)) begin
         to_cnt_reg <= to_cnt_reg + TO_W'(1);
      end
   end

   // Datapath controls latched in ID and held until the next decode
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regdst_reg <= 1'b0;
         extop_reg  <= 1'b0;
         alusrc_reg <= 1'b0;
         aluop_reg  <= ALU_ADD;
         is_lw_reg  <= 1'b0;
         is_sw_reg  <= 1'b0;
         is_beq_reg <= 1'b0;
      end else if (ctl_load) begin
         regdst_reg <= dec_regdst;
         extop_reg  <= dec_extop;
         alusrc_reg <= dec_alusrc;
         aluop_reg  <= dec_aluop;
         is_lw_reg  <= dec_lw;
         is_sw_reg  <= dec_sw;
         is_beq_reg <= dec_beq;
      end
   end

   assign regdst = regdst_reg;
   assign extop  = extop_reg;
   assign alusrc = alusrc_reg;
   assign aluop  = aluop_reg;
   assign state  = state_reg;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Testbench for multi_cycle_ctrl. For each instruction, an instruction-level
// reference model expands the opcode and the chosen ready wait counts into the
// cycle-by-cycle stimulus and expected outputs. Every cycle is then compared.
module tb_multi_cycle_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] op, funct;
   logic       zero, imem_ready, dmem_ready;
   logic       imem_req, ir_write, pc_write, reg_write, regdst, extop, alusrc;
   logic       memread, memwrite, illegal, bus_err, instr_done;
   logic [1:0] pc_src;
   logic [2:0] aluop;
   logic [2:0] state;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3, SLT = 3'd4, LUI = 3'd5;
   localparam logic [19:0] RESET_VEC = {17'b0, ADD};
   localparam logic [19:0] NO_CTL    = 20'hFFFC0;

   always #5 clk = ~clk;

   multi_cycle_ctrl #(.ALUOP_W(3), .MEM_TIMEOUT(15), .TO_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
      .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
      .reg_write(reg_write), .regdst(regdst), .extop(extop), .alusrc(alusrc),
      .aluop(aluop), .memread(memread), .memwrite(memwrite), .illegal(illegal),
      .bus_err(bus_err), .instr_done(instr_done), .state(state)
   );

   // Output vector fields: [19:17] state, [16] imem_req, [15] ir_write, [14] pc_write,
   // [13:12] pc_src, [11] reg_write, [10] memread, [9] memwrite, [8] illegal,
   // [7] bus_err, [6] instr_done, [5] regdst, [4] extop, [3] alusrc, [2:0] aluop
   logic [19:0] act;
   assign act = {state, imem_req, ir_write, pc_write, pc_src, reg_write, memread,
                 memwrite, illegal, bus_err, instr_done, regdst, extop, alusrc, aluop};

   typedef struct packed {
      logic [5:0]  op;
      logic [5:0]  funct;
      logic        zero;
      logic        iready;
      logic        dready;
      logic        chk_ctl;
      logic [19:0] exp;
   } ent_t;

   ent_t q[$];

   function automatic logic r1();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [5:0] r6();
      return 6'($urandom);
   endfunction

   function automatic logic [19:0] pk(input logic [2:0] st, input logic ireq, irw, pcw,
                                      input logic [1:0] psrc, input logic rw, mr, mw, ill, be,
                                      done, input logic [5:0] ctl);
      return {st, ireq, irw, pcw, psrc, rw, mr, mw, ill, be, done, ctl};
   endfunction

   task automatic push(input logic [5:0] o, f, input logic z, ir, dr, cc, input logic [19:0] e);
      ent_t x;
      x.op = o; x.funct = f; x.zero = z; x.iready = ir; x.dready = dr;
      x.chk_ctl = cc; x.exp = e;
      q.push_back(x);
   endtask

   // Reference model: the expected behaviour of one instruction. ifw/memw are
   // the number of low cycles before the corresponding ready rises. A run of
   // 16 consecutive low cycles is a timeout.
   task automatic build(input logic [5:0] o, f, input logic z, input int ifw, memw);
      int kind;            // 0 illegal, 1 R, 2 ALU-imm, 3 lw, 4 sw, 5 beq, 6 j
      logic [5:0] ctl;     // {regdst, extop, alusrc, aluop}
      logic mr, mw;
      kind = 0;
      ctl  = 6'd0;
      case (o)
         6'b000000: begin
            kind = 1;
            case (f)
               6'b100000, 6'b100001: ctl = {3'b100, ADD};
               6'b100011:            ctl = {3'b100, SUB};
               6'b100100:            ctl = {3'b100, AND_};
               6'b100101:            ctl = {3'b100, OR_};
               6'b101010:            ctl = {3'b100, SLT};
               default:              kind = 0;
            endcase
         end
         6'b001000, 6'b001001: begin kind = 2; ctl = {3'b011, ADD};  end
         6'b001100:            begin kind = 2; ctl = {3'b001, AND_}; end
         6'b001101:            begin kind = 2; ctl = {3'b001, OR_};  end
         6'b001111:            begin kind = 2; ctl = {3'b001, LUI};  end
         6'b100011:            begin kind = 3; ctl = {3'b011, ADD};  end
         6'b101011:            begin kind = 4; ctl = {3'b011, ADD};  end
         6'b000100:            begin kind = 5; ctl = {3'b010, SUB};  end
         6'b000010:            kind = 6;
         default:              kind = 0;
      endcase
      // fetch
      for (int i = 0; i < ifw; i++)
         push(r6(), r6(), r1(), 1'b0, r1(), 1'b0,
              pk(3'd0, 1, 0, 0, 2'd0, 0, 0, 0, 0, (i % 16) == 15, 0, 6'd0));
      push(r6(), r6(), r1(), 1'b1, r1(), 1'b0, pk(3'd0, 1, 1, 1, 2'd0, 0, 0, 0, 0, 0, 0, 6'd0));
      // decode
      if (kind == 6) begin
         push(o, f, r1(), r1(), r1(), 1'b0, pk(3'd1, 0, 0, 1, 2'd2, 0, 0, 0, 0, 0, 1, 6'd0));
         return;
      end
      if (kind == 0) begin
         push(o, f, r1(), r1(), r1(), 1'b0, pk(3'd1, 0, 0, 0, 2'd0, 0, 0, 0, 1, 0, 1, 6'd0));
         return;
      end
      push(o, f, r1(), r1(), r1(), 1'b0, pk(3'd1, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 6'd0));
      // execute
      if (kind == 5) begin
         push(o, f, z, r1(), r1(), 1'b1, pk(3'd2, 0, 0, z, 2'd1, 0, 0, 0, 0, 0, 1, ctl));
         return;
      end
      push(o, f, r1(), r1(), r1(), 1'b1, pk(3'd2, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, ctl));
      // memory
      if (kind == 3 || kind == 4) begin
         mr = (kind == 3);
         mw = (kind == 4);
         for (int i = 0; i < memw; i++) begin
            push(o, f, r1(), r1(), 1'b0, 1'b1,
                 pk(3'd3, 0, 0, 0, 2'd0, 0, mr, mw, 0, i == 15, i == 15, ctl));
            if (i == 15) return;
         end
         push(o, f, r1(), r1(), 1'b1, 1'b1, pk(3'd3, 0, 0, 0, 2'd0, 0, mr, mw, 0, 0, mw, ctl));
         if (kind == 4) return;
      end
      // write-back
      push(o, f, r1(), r1(), r1(), 1'b1, pk(3'd4, 0, 0, 0, 2'd0, 1, 0, 0, 0, 0, 1, ctl));
   endtask

   task automatic check_int(input string name, input int got, input int expv);
      checks++;
      if (got != expv) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, got, expv);
      end
   endtask

   task automatic check_vec(input string name, input logic [19:0] got, input logic [19:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, got, expv);
      end
   endtask

   // Plays up to n queued cycles: drive after the rising edge, compare at the falling edge
   task automatic run_n(input int n);
      ent_t e;
      logic [19:0] m;
      for (int k = 0; k < n && q.size() > 0; k++) begin
         e = q.pop_front();
         #1;
         op = e.op; funct = e.funct; zero = e.zero;
         imem_ready = e.iready; dmem_ready = e.dready;
         @(negedge clk);
         cyc++;
         m = e.chk_ctl ? 20'hFFFFF : NO_CTL;
         check_vec($sformatf("cycle%0d_outputs", cyc), act & m, e.exp & m);
         @(posedge clk);
      end
   endtask

   task automatic run_instr(input string tag, input logic [5:0] o, f, input logic z,
                            input int ifw, memw);
      build(o, f, z, ifw, memw);
      $display("instr %s op=%b funct=%b zero=%0d ifw=%0d memw=%0d cycles=%0d",
               tag, o, f, z, ifw, memw, q.size());
      run_n(q.size());
   endtask

   function automatic int count_bit(input int b);
      int c = 0;
      foreach (q[i]) if (q[i].exp[b]) c++;
      return c;
   endfunction

   logic [5:0] legal_f [6] = '{6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101010};
   logic [5:0] rop, rf;
   int         sel, ifw, memw;

   initial begin
      rst_n = 1'b0; op = '0; funct = '0; zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_vec("reset_outputs", act, RESET_VEC);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check_vec("release_before_edge", act, RESET_VEC);
      @(posedge clk);

      // model pins: hand-derived latencies and key pulses
      build(6'b000000, 6'b100000, 1'b0, 0, 0);
      check_int("r_add_latency", q.size(), 4);
      check_int("r_add_wb_regdst", int'(q[3].exp[5]), 1);
      run_n(q.size());
      build(6'b100011, 6'd0, 1'b0, 0, 3);
      check_int("lw_wait3_latency", q.size(), 8);
      check_int("lw_memread_cycles", count_bit(10), 4);
      run_n(q.size());
      build(6'b000100, 6'd0, 1'b1, 0, 0);
      check_int("beq_taken_latency", q.size(), 3);
      check_int("beq_taken_pcwrite", int'(q[2].exp[14]), 1);
      run_n(q.size());
      build(6'b000100, 6'd0, 1'b0, 0, 0);
      check_int("beq_not_taken_pcwrite", int'(q[2].exp[14]), 0);
      run_n(q.size());
      build(6'b101011, 6'd0, 1'b0, 0, 40);
      check_int("sw_timeout_memwrite_cycles", count_bit(9), 16);
      check_int("sw_timeout_bus_err", count_bit(7), 1);
      run_n(q.size());
      build(6'b101011, 6'd0, 1'b0, 0, 15);
      check_int("sw_late_ready_memwrite_cycles", count_bit(9), 16);
      check_int("sw_late_ready_no_bus_err", count_bit(7), 0);
      run_n(q.size());
      build(6'b000010, 6'd0, 1'b0, 0, 0);
      check_int("j_latency", q.size(), 2);
      run_n(q.size());
      run_instr("illegal_op", 6'b111111, 6'd0, 1'b0, 0, 0);
      build(6'b000000, 6'b000000, 1'b0, 0, 0);
      check_int("illegal_funct_latency", q.size(), 2);
      check_int("illegal_funct_pulse", int'(q[1].exp[8]), 1);
      run_n(q.size());
      build(6'b001000, 6'd0, 1'b0, 16, 0);
      check_int("if_timeout_bus_err", int'(q[15].exp[7]), 1);
      run_n(q.size());

      // reset while an lw is waiting in MEM
      build(6'b100011, 6'd0, 1'b0, 0, 20);
      run_n(5);
      check_int("mid_mem_memread_seen", int'(memread), 1);
      #1 rst_n = 1'b0;
      #1 check_vec("reset_mid_mem", act, RESET_VEC);
      q.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check_vec("after_mid_mem_reset", act, RESET_VEC);
      @(posedge clk);

      // randomized instruction stream
      for (int n = 0; n < 250; n++) begin
         sel = $urandom_range(0, 19);
         rf  = legal_f[$urandom_range(0, 5)];
         case (sel)
            0, 1, 2, 17, 18: rop = 6'b000000;
            3:               begin rop = 6'b000000; rf = r6(); end
            4:               rop = 6'b001000;
            5:               rop = 6'b001001;
            6:               rop = 6'b001100;
            7:               rop = 6'b001101;
            8:               rop = 6'b001111;
            9, 10:           rop = 6'b100011;
            11, 12:          rop = 6'b101011;
            13, 14:          rop = 6'b000100;
            15:              rop = 6'b000010;
            default:         rop = r6();
         endcase
         ifw  = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(13, 17);
         memw = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 3) : $urandom_range(14, 17);
         run_instr($sformatf("rand%0d", n), rop, rf, r1(), ifw, memw);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
